// File: rtl/tempo_pkg.sv
// Shared types and helpers for the metronome tempo source.
// Used by tempo_ctrl and its sequential divider period_div.
package tempo_pkg;

    localparam int BPM_W          = 8;
    localparam int PERIOD_W       = 32;
    localparam int BCD_W          = 4;
    localparam int SW_W           = 5;

    localparam int CLK_HZ_DEF     = 50_000_000;
    localparam int BPM_MIN_DEF    = 40;
    localparam int BPM_MAX_DEF    = 240;
    localparam int BPM_RESET_DEF  = 120;

    // Presets stop growing above this switch index (60 + 10*17 = 230).
    localparam int PRESET_IDX_MAX = 17;

    typedef enum logic {IDLE = 1'b0, DIV = 1'b1} div_state_e;

    function automatic logic [3*BCD_W-1:0] bin_to_bcd(input logic [BPM_W-1:0] bin);
        logic [3*BCD_W+BPM_W-1:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < BPM_W; i++) begin
            sh[11:8]  = (sh[11:8]  >= 4'd5) ? sh[11:8]  + 4'd3 : sh[11:8];
            sh[15:12] = (sh[15:12] >= 4'd5) ? sh[15:12] + 4'd3 : sh[15:12];
            sh[19:16] = (sh[19:16] >= 4'd5) ? sh[19:16] + 4'd3 : sh[19:16];
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

    function automatic logic [BPM_W-1:0] preset_bpm(input logic [SW_W-1:0] idx, input int bpm_max);
        int sel;
        int v;
        sel = (int'(idx) > PRESET_IDX_MAX) ? PRESET_IDX_MAX : int'(idx);
        v   = 32'sd60 + 32'sd10 * sel;
        return (v > bpm_max) ? BPM_W'(bpm_max) : BPM_W'(v);
    endfunction

endpackage

// File: rtl/period_div.sv
// Start/busy/done restoring divider: one quotient bit per cycle, PERIOD_W cycles.
// A start while busy abandons the running division and reloads the operands.
module period_div
    import tempo_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [PERIOD_W-1:0] dividend,
    input  logic [BPM_W-1:0]    divisor,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] quotient
);

    div_state_e          state_r, state_nx_s;
    logic [4:0]          cnt_r;
    logic [PERIOD_W-1:0] q_r, q_nx_s;
    logic [BPM_W-1:0]    rem_r, rem_nx_s, dvs_r;
    logic [BPM_W:0]      trial_s, diff_s;
    logic                ge_s;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        trial_s  = {rem_r, q_r[PERIOD_W-1]};
        diff_s   = trial_s - {1'b0, dvs_r};
        ge_s     = (trial_s >= {1'b0, dvs_r});
        rem_nx_s = ge_s ? diff_s[BPM_W-1:0] : trial_s[BPM_W-1:0];
        q_nx_s   = {q_r[PERIOD_W-2:0], ge_s};
    end

    // Next-state logic and completion strobe.
    always_comb begin
        state_nx_s = state_r;
        done       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = DIV;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DIV: begin
                if (start) begin
                    state_nx_s = DIV;
                end else if (cnt_r == 5'd31) begin
                    state_nx_s = IDLE;
                    done       = 1'b1;
                end else begin
                    state_nx_s = DIV;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            q_r     <= '0;
            rem_r   <= '0;
            dvs_r   <= '0;
        end else begin
            state_r <= state_nx_s;
            if (start) begin
                cnt_r <= 5'd0;
                q_r   <= dividend;
                rem_r <= '0;
                dvs_r <= divisor;
            end else if (state_r == DIV) begin
                cnt_r <= cnt_r + 5'd1;
                q_r   <= q_nx_s;
                rem_r <= rem_nx_s;
            end
        end
    end

    assign busy     = (state_r == DIV);
    assign quotient = q_nx_s;

endmodule

// File: rtl/tempo_ctrl.sv
// Debounced, clamped BPM source with BCD digits and a sequentially divided beat period.
// Optional feature macro: TEMPO_AUTOREPEAT_EN (held buttons repeat after 0.5 s every 0.1 s).
module tempo_ctrl
    import tempo_pkg::*;
#(
    parameter int CLK_HZ          = CLK_HZ_DEF,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BPM_MIN         = BPM_MIN_DEF,
    parameter int BPM_MAX         = BPM_MAX_DEF,
    parameter int BPM_RESET       = BPM_RESET_DEF
)(
    input  logic                clock,
    input  logic                reset,
    input  logic [SW_W-1:0]     sw,
    input  logic                tapdown,
    input  logic                tapup,
    output logic [BPM_W-1:0]    bpm,
    output logic [BCD_W-1:0]    hex100,
    output logic [BCD_W-1:0]    hex10,
    output logic [BCD_W-1:0]    hex0,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    localparam longint unsigned  DIVIDEND_L   = longint'(CLK_HZ) * 64'd60;
    localparam logic [PERIOD_W-1:0] DIVIDEND  = PERIOD_W'(DIVIDEND_L);
    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(DIVIDEND_L / longint'(BPM_RESET));
    localparam logic [BPM_W-1:0] BPM_MIN_B    = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] BPM_MAX_B    = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] BPM_RST_B    = BPM_W'(BPM_RESET);
    localparam logic [3*BCD_W-1:0] BCD_RST    = bin_to_bcd(BPM_RST_B);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NCH   = 3;
    localparam int CH_SW = 0;
    localparam int CH_UP = 1;
    localparam int CH_DN = 2;

    // Buttons are active-low, so their released value is 1; sw rests at 0.
    function automatic logic [SW_W-1:0] ch_rst(input int ch);
        return (ch == CH_SW) ? 5'b00000 : 5'b00001;
    endfunction

    logic [SW_W-1:0]  raw_s [NCH];
    logic [SW_W-1:0]  s0_r [NCH], s1_r [NCH], prev_r [NCH], db_r [NCH], db_dly_r [NCH];
    logic [CNT_W-1:0] cnt_r [NCH], cnt_nx_s [NCH];
    logic [NCH-1:0]   accept_s;
    logic             sw_chg_s, up_ev_s, dn_ev_s, up_any_s, dn_any_s;
    logic [1:0]       rep_ev_s;
    logic [BPM_W-1:0] bpm_r, bpm_nx_s;
    logic             bpm_chg_r;
    logic [3*BCD_W-1:0] bcd_r;
    logic [PERIOD_W-1:0] period_r, quot_s;
    logic             valid_r, div_busy_s, div_done_s;

    // Inputs widened to a common width so one debouncer loop covers all channels.
    always_comb begin
        raw_s[CH_SW] = sw;
        raw_s[CH_UP] = {4'b0000, tapup};
        raw_s[CH_DN] = {4'b0000, tapdown};
    end

    // Run length of the current synchronised value, and whether it has been stable long enough.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            cnt_nx_s[ch] = (s1_r[ch] != prev_r[ch]) ? CNT_W'(1) : cnt_r[ch] + CNT_W'(1);
            accept_s[ch] = (s1_r[ch] != db_r[ch]) && (cnt_nx_s[ch] >= CNT_W'(DEBOUNCE_CYCLES));
        end
    end

    // Synchronisers and debounce counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                s0_r[ch]     <= ch_rst(ch);
                s1_r[ch]     <= ch_rst(ch);
                prev_r[ch]   <= ch_rst(ch);
                db_r[ch]     <= ch_rst(ch);
                db_dly_r[ch] <= ch_rst(ch);
                cnt_r[ch]    <= '0;
            end
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                s0_r[ch]     <= raw_s[ch];
                s1_r[ch]     <= s0_r[ch];
                prev_r[ch]   <= s1_r[ch];
                db_dly_r[ch] <= db_r[ch];
                if (s1_r[ch] == db_r[ch]) begin
                    cnt_r[ch] <= '0;
                end else if (accept_s[ch]) begin
                    db_r[ch]  <= s1_r[ch];
                    cnt_r[ch] <= '0;
                end else begin
                    cnt_r[ch] <= cnt_nx_s[ch];
                end
            end
        end
    end

    assign sw_chg_s = (db_r[CH_SW] != db_dly_r[CH_SW]);
    assign up_ev_s  = db_dly_r[CH_UP][0] & ~db_r[CH_UP][0];
    assign dn_ev_s  = db_dly_r[CH_DN][0] & ~db_r[CH_DN][0];

`ifdef TEMPO_AUTOREPEAT_EN
    localparam logic [31:0] HOLD_CYC = 32'(CLK_HZ / 2);
    localparam logic [31:0] RATE_CYC = 32'(CLK_HZ / 10);
    logic [31:0] rep_cnt_r [2];
    logic [1:0]  rep_arm_r, held_s;

    // A repeat fires when the hold (first) or rate (later) interval expires.
    always_comb begin
        held_s = {~db_r[CH_DN][0], ~db_r[CH_UP][0]};
        for (int b = 0; b < 2; b++) begin
            rep_ev_s[b] = held_s[b] &&
                (rep_cnt_r[b] == (rep_arm_r[b] ? RATE_CYC - 32'd1 : HOLD_CYC - 32'd1));
        end
    end

    // Hold-time counters, cleared on release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_cnt_r[0] <= 32'd0;
            rep_cnt_r[1] <= 32'd0;
            rep_arm_r    <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!held_s[b]) begin
                    rep_cnt_r[b] <= 32'd0;
                    rep_arm_r[b] <= 1'b0;
                end else if (rep_ev_s[b]) begin
                    rep_cnt_r[b] <= 32'd0;
                    rep_arm_r[b] <= 1'b1;
                end else begin
                    rep_cnt_r[b] <= rep_cnt_r[b] + 32'd1;
                end
            end
        end
    end
`else
    // Repeat feature not built.
    always_comb rep_ev_s = 2'b00;
`endif

    assign up_any_s = up_ev_s | rep_ev_s[0];
    assign dn_any_s = dn_ev_s | rep_ev_s[1];

    // Tempo update: preset load wins and swallows key events; keys clamp without wrap.
    always_comb begin
        bpm_nx_s = bpm_r;
        if (sw_chg_s) begin
            bpm_nx_s = preset_bpm(db_r[CH_SW], BPM_MAX);
        end else if (up_any_s && dn_any_s) begin
            bpm_nx_s = bpm_r;
        end else if (up_any_s) begin
            bpm_nx_s = (bpm_r >= BPM_MAX_B) ? BPM_MAX_B : bpm_r + 8'd1;
        end else if (dn_any_s) begin
            bpm_nx_s = (bpm_r <= BPM_MIN_B) ? BPM_MIN_B : bpm_r - 8'd1;
        end else begin
            bpm_nx_s = bpm_r;
        end
    end

    // Tempo, change strobe, BCD digits and published period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bpm_r     <= BPM_RST_B;
            bpm_chg_r <= 1'b0;
            bcd_r     <= BCD_RST;
            period_r  <= PERIOD_RST;
            valid_r   <= 1'b1;
        end else begin
            bpm_r     <= bpm_nx_s;
            bpm_chg_r <= (bpm_nx_s != bpm_r);
            bcd_r     <= bin_to_bcd(bpm_r);
            if (bpm_chg_r) begin
                valid_r <= 1'b0;
            end else if (div_done_s && div_busy_s) begin
                period_r <= quot_s;
                valid_r  <= 1'b1;
            end
        end
    end

    period_div u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (bpm_chg_r),
        .dividend (DIVIDEND),
        .divisor  (bpm_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (quot_s)
    );

    assign bpm          = bpm_r;
    assign hex100       = bcd_r[11:8];
    assign hex10        = bcd_r[7:4];
    assign hex0         = bcd_r[3:0];
    assign period       = period_r;
    assign period_valid = valid_r;

endmodule

// File: tb/tb_tempo_ctrl.sv
// Self-checking bench for tempo_ctrl: directed scenarios then random button/switch traffic
// compared against an arithmetic tempo model.
module tb_tempo_ctrl;

    localparam int CLK_HZ = 1000;
    localparam int DEB    = 4;
    localparam int BMIN   = 40;
    localparam int BMAX   = 230;
    localparam int BRST   = 120;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  sw = 5'd0;
    logic        tapdown = 1'b1;
    logic        tapup = 1'b1;
    logic [7:0]  bpm;
    logic [3:0]  hex100, hex10, hex0;
    logic [31:0] period;
    logic        period_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int bpm_m;
    int sw_m;

    tempo_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB),
        .BPM_MIN         (BMIN),
        .BPM_MAX         (BMAX),
        .BPM_RESET       (BRST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sw           (sw),
        .tapdown      (tapdown),
        .tapup        (tapup),
        .bpm          (bpm),
        .hex100       (hex100),
        .hex10        (hex10),
        .hex0         (hex0),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int preset_m(input int s);
        int t;
        t = 60 + 10 * ((s < 17) ? s : 17);
        return (t > BMAX) ? BMAX : t;
    endfunction

    task automatic wait_valid();
        int k;
        k = 0;
        while (!period_valid && k < 80) begin
            tick(1);
            k++;
        end
        check("valid_wait", int'(period_valid), 1);
    endtask

    task automatic check_state();
        check("bpm", int'(bpm), bpm_m);
        check("hex100", int'(hex100), bpm_m / 100);
        check("hex10", int'(hex10), (bpm_m / 10) % 10);
        check("hex0", int'(hex0), bpm_m % 10);
        wait_valid();
        check("period", int'(period), (CLK_HZ * 60) / bpm_m);
    endtask

    task automatic do_preset(input int s);
        sw = 5'(s);
        tick(14);
        if (s != sw_m) begin
            sw_m  = s;
            bpm_m = preset_m(s);
        end
    endtask

    task automatic press(input bit up, input bit dn);
        tapup   = ~up;
        tapdown = ~dn;
        tick(10);
        tapup   = 1'b1;
        tapdown = 1'b1;
        tick(10);
        if (up && !dn) bpm_m = (bpm_m + 1 > BMAX) ? BMAX : bpm_m + 1;
        else if (dn && !up) bpm_m = (bpm_m - 1 < BMIN) ? BMIN : bpm_m - 1;
    endtask

    task automatic glitch();
        tapup = 1'b0;
        tick(2);
        tapup = 1'b1;
        tick(12);
    endtask

    task automatic wait_bpm_leave(input int old_bpm);
        int k;
        k = 0;
        while (int'(bpm) == old_bpm && k < 40) begin
            tick(1);
            k++;
        end
        check("bpm_change_seen", (int'(bpm) != old_bpm) ? 1 : 0, 1);
    endtask

    // Counts cycles from the last bpm update until period_valid returns.
    task automatic measure_div(input int old_bpm, input int old_period,
                               output int n_cyc, output int n_low, output int n_bad);
        n_cyc = 0;
        n_low = 0;
        n_bad = 0;
        wait_bpm_leave(old_bpm);
        while (n_cyc < 100) begin
            tick(1);
            n_cyc++;
            if (!period_valid) begin
                n_low++;
                if (int'(period) != old_period) n_bad++;
            end else if (n_cyc >= 2) begin
                break;
            end
        end
    endtask

    task automatic do_reset();
        sw    = 5'd0;
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        bpm_m = BRST;
        sw_m  = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nc, nl, nb, r;
        do_reset();
        check("rst_bpm", int'(bpm), 120);
        check("rst_hex100", int'(hex100), 1);
        check("rst_hex10", int'(hex10), 2);
        check("rst_hex0", int'(hex0), 0);
        check("rst_period", int'(period), 500);
        check("rst_valid", int'(period_valid), 1);

        // Preset load and divider latency.
        sw = 5'd3;
        measure_div(120, 500, nc, nl, nb);
        check("div_latency", nc, 33);
        check("div_low_cycles", nl, 32);
        check("div_hold_period", nb, 0);
        sw_m = 3;
        bpm_m = 90;
        check_state();
        check("period_90", int'(period), 666);

        // Single presses and a glitch.
        do_reset();
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check_state();
        check("bpm_123", int'(bpm), 123);
        glitch();
        check_state();

        // Upper clamp: no change and no division started.
        do_preset(31);
        check_state();
        press(1'b1, 1'b0);
        check("clamp_hi_nodiv", int'(period_valid), 1);
        check_state();

        // Lower clamp.
        do_preset(0);
        check_state();
        for (int i = 0; i < 19; i++) press(1'b0, 1'b1);
        check_state();
        for (int i = 0; i < 2; i++) press(1'b0, 1'b1);
        check("clamp_lo_nodiv", int'(period_valid), 1);
        check_state();

        // Simultaneous presses cancel.
        press(1'b1, 1'b1);
        check_state();

        // Second change while dividing restarts the division.
        sw = 5'd2;
        wait_bpm_leave(40);
        tick(3);
        sw = 5'd4;
        measure_div(80, 1500, nc, nl, nb);
        check("restart_latency", nc, 33);
        check("restart_hold", nb, 0);
        sw_m = 4;
        bpm_m = preset_m(4);
        check_state();

        // Reset in the middle of a division.
        sw = 5'd7;
        wait_bpm_leave(100);
        tick(5);
        reset = 1'b0;
        sw = 5'd0;
        #1;
        check("mid_rst_bpm", int'(bpm), 120);
        check("mid_rst_period", int'(period), 500);
        check("mid_rst_valid", int'(period_valid), 1);
        tick(3);
        reset = 1'b1;
        bpm_m = BRST;
        sw_m = 0;
        tick(50);
        check("idle_after_rst", int'(period_valid), 1);
        check_state();

`ifndef TEMPO_AUTOREPEAT_EN
        // A long hold gives exactly one event.
        tapup = 1'b0;
        tick(1200);
        tapup = 1'b1;
        tick(12);
        bpm_m = bpm_m + 1;
        check_state();
`endif

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) do_preset(int'($urandom_range(0, 31)));
            else if (r < 5) press(1'b1, 1'b0);
            else if (r < 8) press(1'b0, 1'b1);
            else if (r == 8) press(1'b1, 1'b1);
            else glitch();
            check_state();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
